// File: rtl/apb_inbuf_stream_ctrl.sv
// APB slave feeding the input-buffer core: packs bus writes into CH_NUM-bit FIFO entries,
// issues commands with a valid/ready handshake, and unpacks one captured output word into reads.
module apb_inbuf_stream_ctrl #(
    parameter int unsigned BUS_AW     = 8,
    parameter int unsigned BUS_DW     = 32,
    parameter int unsigned CH_NUM     = 128,
    parameter int unsigned OUT_MULT   = 9,
    parameter int unsigned IB_SRAM_AW = 10,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic [BUS_AW-1:0]            apb_paddr_s,
    input  logic                         apb_pwrite_s,
    input  logic                         apb_psel_s,
    input  logic                         apb_penable_s,
    input  logic [BUS_DW-1:0]            apb_pwdata_s,
    output logic [BUS_DW-1:0]            apb_prdata_s,
    output logic                         apb_pready_s,
    output logic [CH_NUM-1:0]            inbuf_din_o,
    output logic                         inbuf_din_vld_o,
    input  logic                         inbuf_din_rdy_i,
    output logic                         inbuf_sop_o,
    output logic                         inbuf_hsync_o,
    output logic [IB_SRAM_AW-1:0]        inbuf_start_waddr_o,
    input  logic [CH_NUM*OUT_MULT-1:0]   inbuf_dout_i,
    input  logic                         inbuf_dout_vld_i,
    output logic                         inbuf_dout_rdy_o,
    output logic [7:0]                   inbuf_pic_size_o,
    output logic [3:0]                   inbuf_mode_o,
    output logic                         inbuf_padding_o,
    output logic                         inbuf_cmd_vld_o,
    input  logic                         inbuf_cmd_rdy_i
);

    localparam int unsigned DOUT_W = CH_NUM * OUT_MULT;
    localparam int unsigned N_IN   = CH_NUM / BUS_DW;
    localparam int unsigned N_OUT  = DOUT_W / BUS_DW;
    localparam int unsigned IN_IW  = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int unsigned OUT_IW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int unsigned PW     = $clog2(FIFO_DEPTH);

    localparam logic [2:0] ADDR_DIN    = 3'd0;
    localparam logic [2:0] ADDR_FLAGS  = 3'd1;
    localparam logic [2:0] ADDR_WADDR  = 3'd2;
    localparam logic [2:0] ADDR_CMD    = 3'd3;
    localparam logic [2:0] ADDR_STATUS = 3'd4;
    localparam logic [2:0] ADDR_DOUT   = 3'd5;
    localparam logic [2:0] ADDR_CTRL   = 3'd6;

    logic [CH_NUM+1:0]     mem_q [FIFO_DEPTH];
    logic [PW:0]           wptr_q, rptr_q, count;
    logic [CH_NUM-1:0]     din_buf_q, push_word;
    logic [IN_IW-1:0]      din_idx_q;
    logic [1:0]            flags_q;
    logic [IB_SRAM_AW-1:0] waddr_q;
    logic [12:0]           cmd_q;
    logic                  cmd_vld_q;
    logic [DOUT_W-1:0]     cap_q;
    logic                  captured_q;
    logic [OUT_IW-1:0]     dout_idx_q;
    logic [CH_NUM+1:0]     head;
    logic [31:0]           status;
    logic [2:0]            addr_idx;
    logic rd, wr, full, empty, din_final, din_wr, push, pop, flush, capture, dout_rd, dout_last;
    logic unused_bits;

    assign unused_bits = ^{apb_paddr_s[BUS_AW-1:5], apb_paddr_s[1:0], apb_pwdata_s};

    assign addr_idx  = apb_paddr_s[4:2];
    assign rd        = apb_psel_s & apb_penable_s & ~apb_pwrite_s;
    assign wr        = apb_psel_s & apb_penable_s & apb_pwrite_s;
    assign count     = wptr_q - rptr_q;
    assign full      = (count == (PW+1)'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign din_final = (din_idx_q == IN_IW'(N_IN - 1));
    // Only the word-completing slice can stall, and only while the FIFO is full.
    assign apb_pready_s = !(wr && addr_idx == ADDR_DIN && din_final && full);
    assign din_wr    = wr && addr_idx == ADDR_DIN && apb_pready_s;
    assign push      = din_wr && din_final;
    assign pop       = ~empty & inbuf_din_rdy_i;
    assign flush     = wr && addr_idx == ADDR_CTRL && apb_pwdata_s[0];
    assign capture   = inbuf_dout_vld_i & ~captured_q;
    assign dout_rd   = rd && addr_idx == ADDR_DOUT && captured_q;
    assign dout_last = (dout_idx_q == OUT_IW'(N_OUT - 1));

    always_comb begin
        push_word = din_buf_q;
        push_word[CH_NUM-BUS_DW +: BUS_DW] = apb_pwdata_s;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else if (flush) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push) begin
                mem_q[wptr_q[PW-1:0]] <= {flags_q[1], flags_q[0], push_word};
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop) rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            din_buf_q <= '0;
            din_idx_q <= '0;
            flags_q   <= '0;
        end else if (flush) begin
            din_idx_q <= '0;
            flags_q   <= '0;
        end else if (din_wr) begin
            din_buf_q[int'(din_idx_q) * BUS_DW +: BUS_DW] <= apb_pwdata_s;
            din_idx_q <= din_final ? '0 : din_idx_q + 1'b1;
            if (push) flags_q <= '0;
        end else if (wr && addr_idx == ADDR_FLAGS) begin
            flags_q <= apb_pwdata_s[1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            waddr_q   <= '0;
            cmd_q     <= '0;
            cmd_vld_q <= 1'b0;
        end else begin
            if (wr && addr_idx == ADDR_WADDR) waddr_q <= apb_pwdata_s[IB_SRAM_AW-1:0];
            // Fields are frozen while a command is pending so the core sees stable values.
            if (wr && addr_idx == ADDR_CMD && !cmd_vld_q) begin
                cmd_q     <= apb_pwdata_s[12:0];
                cmd_vld_q <= apb_pwdata_s[31];
            end else if (cmd_vld_q && inbuf_cmd_rdy_i) begin
                cmd_vld_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cap_q      <= '0;
            captured_q <= 1'b0;
            dout_idx_q <= '0;
        end else if (flush) begin
            captured_q <= 1'b0;
            dout_idx_q <= '0;
        end else if (capture) begin
            cap_q      <= inbuf_dout_i;
            captured_q <= 1'b1;
        end else if (dout_rd) begin
            captured_q <= !dout_last;
            dout_idx_q <= dout_last ? '0 : dout_idx_q + 1'b1;
        end
    end

    always_comb begin
        status        = '0;
        status[0]     = full;
        status[1]     = empty;
        status[2]     = cmd_vld_q;
        status[3]     = captured_q;
        status[14:8]  = 7'(count);
        status[23:16] = 8'(din_idx_q);
        status[31:24] = 8'(dout_idx_q);
    end

    always_comb begin
        apb_prdata_s = '0;
        if (rd) begin
            case (addr_idx)
                ADDR_FLAGS:  apb_prdata_s[1:0] = flags_q;
                ADDR_WADDR:  apb_prdata_s[IB_SRAM_AW-1:0] = waddr_q;
                ADDR_CMD:    apb_prdata_s[12:0] = cmd_q;
                ADDR_STATUS: apb_prdata_s = BUS_DW'(status);
                ADDR_DOUT: begin
                    if (captured_q) apb_prdata_s = cap_q[int'(dout_idx_q) * BUS_DW +: BUS_DW];
                end
                default:     apb_prdata_s = '0;
            endcase
        end
    end

    assign head                = mem_q[rptr_q[PW-1:0]];
    assign inbuf_din_o         = head[CH_NUM-1:0];
    assign inbuf_din_vld_o     = ~empty;
    assign inbuf_sop_o         = head[CH_NUM] & ~empty;
    assign inbuf_hsync_o       = head[CH_NUM+1] & ~empty;
    assign inbuf_start_waddr_o = waddr_q;
    assign inbuf_dout_rdy_o    = ~captured_q;
    assign inbuf_pic_size_o    = cmd_q[7:0];
    assign inbuf_mode_o        = cmd_q[11:8];
    assign inbuf_padding_o     = cmd_q[12];
    assign inbuf_cmd_vld_o     = cmd_vld_q;

endmodule

// File: tb/tb_apb_inbuf_stream_ctrl.sv
// Scoreboard bench for apb_inbuf_stream_ctrl: stimulus queues expected values, a negedge
// monitor pops and compares on every APB read completion and every queued port probe.
module tb_apb_inbuf_stream_ctrl;

    localparam int DOUT_W = 1152;
    localparam int S_DIN = 1, S_DVLD = 2, S_SOP = 3, S_HSYNC = 4, S_PREADY = 5, S_CMDV = 6;
    localparam int S_PIC = 7, S_MODE = 8, S_PAD = 9, S_DRDY = 10, S_WADDR = 11, S_PRDATA = 12;
    localparam logic [7:0] A_DIN = 8'h00, A_FLAGS = 8'h04, A_WADDR = 8'h08, A_CMD = 8'h0C;
    localparam logic [7:0] A_STATUS = 8'h10, A_DOUT = 8'h14, A_CTRL = 8'h18, A_NONE = 8'h1C;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [7:0]        paddr = '0;
    logic              pwrite = 1'b0, psel = 1'b0, penable = 1'b0;
    logic [31:0]       pwdata = '0;
    logic [31:0]       prdata;
    logic              pready;
    logic [127:0]      din;
    logic              din_vld, din_rdy = 1'b0, sop, hsync;
    logic [9:0]        start_waddr;
    logic [DOUT_W-1:0] dout = '0;
    logic              dout_vld = 1'b0, dout_rdy;
    logic [7:0]        pic_size;
    logic [3:0]        mode;
    logic              padding, cmd_vld, cmd_rdy = 1'b0;

    typedef struct {
        string        name;
        int           sel;
        logic [127:0] exp;
    } chk_t;

    chk_t probe_q[$];
    chk_t read_q[$];
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    apb_inbuf_stream_ctrl dut (
        .clk_i              (clk),
        .rst_n_i            (rst_n),
        .apb_paddr_s        (paddr),
        .apb_pwrite_s       (pwrite),
        .apb_psel_s         (psel),
        .apb_penable_s      (penable),
        .apb_pwdata_s       (pwdata),
        .apb_prdata_s       (prdata),
        .apb_pready_s       (pready),
        .inbuf_din_o        (din),
        .inbuf_din_vld_o    (din_vld),
        .inbuf_din_rdy_i    (din_rdy),
        .inbuf_sop_o        (sop),
        .inbuf_hsync_o      (hsync),
        .inbuf_start_waddr_o(start_waddr),
        .inbuf_dout_i       (dout),
        .inbuf_dout_vld_i   (dout_vld),
        .inbuf_dout_rdy_o   (dout_rdy),
        .inbuf_pic_size_o   (pic_size),
        .inbuf_mode_o       (mode),
        .inbuf_padding_o    (padding),
        .inbuf_cmd_vld_o    (cmd_vld),
        .inbuf_cmd_rdy_i    (cmd_rdy)
    );

    function automatic logic [127:0] sample(int sel);
        case (sel)
            S_DIN:    return din;
            S_DVLD:   return 128'(din_vld);
            S_SOP:    return 128'(sop);
            S_HSYNC:  return 128'(hsync);
            S_PREADY: return 128'(pready);
            S_CMDV:   return 128'(cmd_vld);
            S_PIC:    return 128'(pic_size);
            S_MODE:   return 128'(mode);
            S_PAD:    return 128'(padding);
            S_DRDY:   return 128'(dout_rdy);
            S_WADDR:  return 128'(start_waddr);
            default:  return 128'(prdata);
        endcase
    endfunction

    task automatic compare(input chk_t c, input logic [127:0] act);
        checks++;
        if (act !== c.exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", c.name, act, c.exp);
        end
    endtask

    // Monitor: APB read data on completed read accesses, queued probes every falling edge.
    initial begin
        chk_t c;
        forever begin
            @(negedge clk);
            if (psel && penable && !pwrite && pready) begin
                if (read_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_read: got %0h expected no read", prdata);
                end else begin
                    c = read_q.pop_front();
                    compare(c, 128'(prdata));
                end
            end
            while (probe_q.size() > 0) begin
                c = probe_q.pop_front();
                compare(c, sample(c.sel));
            end
        end
    end

    task automatic probe(input string name, input int sel, input logic [127:0] exp);
        probe_q.push_back('{name, sel, exp});
    endtask

    task automatic apb_xfer(input logic wr, input logic [7:0] a, input logic [31:0] d);
        int n = 0;
        @(posedge clk); #1;
        psel = 1'b1; pwrite = wr; paddr = a; pwdata = d; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        while (!pready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!pready) begin
            checks++;
            failures++;
            $display("FAIL apb_timeout: got pready=0 expected 1 within 200 cycles");
        end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
        apb_xfer(1'b1, a, d);
    endtask

    task automatic apb_read(input string name, input logic [7:0] a, input logic [31:0] exp);
        read_q.push_back('{name, S_PRDATA, 128'(exp)});
        apb_xfer(1'b0, a, 32'h0);
    endtask

    function automatic logic [31:0] slice_val(int k, int j);
        return 32'((k << 24) | j);
    endfunction

    function automatic logic [127:0] word_val(int k);
        logic [127:0] w;
        for (int j = 0; j < 4; j++) w[j*32 +: 32] = slice_val(k, j);
        return w;
    endfunction

    task automatic push_word(input int k);
        for (int j = 0; j < 4; j++) apb_write(A_DIN, slice_val(k, j));
    endtask

    task automatic pulse_capture(input logic [DOUT_W-1:0] v);
        @(posedge clk); #1;
        dout = v; dout_vld = 1'b1;
        @(posedge clk); #1;
        dout_vld = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [DOUT_W-1:0] pat;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        probe("rst_din_vld", S_DVLD, 0);
        probe("rst_sop", S_SOP, 0);
        probe("rst_hsync", S_HSYNC, 0);
        probe("rst_cmd_vld", S_CMDV, 0);
        probe("rst_dout_rdy", S_DRDY, 1);
        probe("rst_pready", S_PREADY, 1);
        probe("rst_prdata", S_PRDATA, 0);
        apb_read("rst_status", A_STATUS, 32'h0000_0002);

        // Packing with flags
        apb_write(A_FLAGS, 32'h3);
        apb_read("flags_rb", A_FLAGS, 32'h3);
        apb_write(A_DIN, 32'h1111_1111);
        apb_write(A_DIN, 32'h2222_2222);
        apb_write(A_DIN, 32'h3333_3333);
        apb_read("status_mid_word", A_STATUS, 32'h0003_0002);
        apb_write(A_DIN, 32'h4444_4444);
        probe("t1_din_vld", S_DVLD, 1);
        probe("t1_din", S_DIN, 128'h44444444_33333333_22222222_11111111);
        probe("t1_sop", S_SOP, 1);
        probe("t1_hsync", S_HSYNC, 1);
        apb_read("t1_flags_clr", A_FLAGS, 32'h0);
        apb_read("t1_status", A_STATUS, 32'h0000_0100);

        // Full-FIFO stall on final slice
        apb_write(A_CTRL, 32'h1);
        for (int k = 1; k <= 4; k++) push_word(k);
        apb_read("t2_status_full", A_STATUS, 32'h0000_0401);
        for (int j = 0; j < 3; j++) apb_write(A_DIN, slice_val(5, j));
        fork
            apb_write(A_DIN, slice_val(5, 3));
            begin
                repeat (3) @(posedge clk);
                #1;
                probe("t2_stall", S_PREADY, 0);
                din_rdy = 1'b1;
                @(posedge clk); #1;
                din_rdy = 1'b0;
                probe("t2_release", S_PREADY, 1);
            end
        join
        probe("t2_head", S_DIN, word_val(2));
        probe("t2_head_sop", S_SOP, 0);
        apb_read("t2_status_after", A_STATUS, 32'h0000_0401);
        apb_write(A_CTRL, 32'h1);

        // Command handshake
        apb_write(A_CMD, 32'h8000_1A20);
        probe("t3_pic", S_PIC, 8'h20);
        probe("t3_mode", S_MODE, 4'hA);
        probe("t3_pad", S_PAD, 1);
        probe("t3_cmd_vld", S_CMDV, 1);
        apb_write(A_CMD, 32'h8000_0000);
        apb_read("t3_cmd_locked", A_CMD, 32'h0000_1A20);
        probe("t3_pic_locked", S_PIC, 8'h20);
        @(posedge clk); #1;
        cmd_rdy = 1'b1;
        probe("t3_vld_hold", S_CMDV, 1);
        @(posedge clk); #1;
        cmd_rdy = 1'b0;
        probe("t3_vld_clr", S_CMDV, 0);
        apb_write(A_WADDR, 32'h0000_0155);
        apb_read("t3_waddr", A_WADDR, 32'h155);
        probe("t3_waddr_port", S_WADDR, 10'h155);

        // Output capture and unpacking
        for (int k = 0; k < 36; k++) pat[k*32 +: 32] = 32'(k);
        pulse_capture(pat);
        probe("t4_dout_rdy0", S_DRDY, 0);
        for (int k = 0; k < 36; k++) begin
            apb_read($sformatf("t4_dout%0d", k), A_DOUT, 32'(k));
            if (k == 4) apb_read("t4_status_idx", A_STATUS, 32'h0500_000A);
            if (k == 34) probe("t4_dout_rdy_busy", S_DRDY, 0);
        end
        probe("t4_dout_rdy1", S_DRDY, 1);
        apb_read("t4_dout_empty", A_DOUT, 32'h0);
        apb_read("t4_status_end", A_STATUS, 32'h0000_0002);

        // Flush
        push_word(7);
        push_word(8);
        apb_write(A_DIN, slice_val(9, 0));
        apb_write(A_DIN, slice_val(9, 1));
        pulse_capture(pat);
        apb_read("t5_status_pre", A_STATUS, 32'h0002_0208);
        apb_write(A_FLAGS, 32'h1);
        apb_write(A_CTRL, 32'h1);
        apb_read("t5_status_post", A_STATUS, 32'h0000_0002);
        apb_read("t5_flags", A_FLAGS, 32'h0);
        apb_read("t5_waddr", A_WADDR, 32'h155);
        apb_read("t5_cmd", A_CMD, 32'h1A20);
        apb_read("t5_unmapped", A_NONE, 32'h0);
        probe("t5_din_vld", S_DVLD, 0);
        probe("t5_dout_rdy", S_DRDY, 1);
        push_word(9);
        probe("t5_repack", S_DIN, word_val(9));

        // Async reset during stall
        for (int k = 10; k <= 12; k++) push_word(k);
        pulse_capture(pat);
        apb_write(A_CMD, 32'h8000_0005);
        probe("t6_pre_cmd_vld", S_CMDV, 1);
        for (int j = 0; j < 3; j++) apb_write(A_DIN, slice_val(13, j));
        fork
            apb_write(A_DIN, slice_val(13, 3));
            begin
                repeat (3) @(posedge clk);
                #1;
                probe("t6_stall", S_PREADY, 0);
                @(posedge clk); #1;
                rst_n = 1'b0;
                #1;
                probe("t6_pready", S_PREADY, 1);
                probe("t6_din_vld", S_DVLD, 0);
                probe("t6_din", S_DIN, 0);
                probe("t6_sop", S_SOP, 0);
                probe("t6_hsync", S_HSYNC, 0);
                probe("t6_cmd_vld", S_CMDV, 0);
                probe("t6_pic", S_PIC, 0);
                probe("t6_dout_rdy", S_DRDY, 1);
                probe("t6_waddr", S_WADDR, 0);
                probe("t6_prdata", S_PRDATA, 0);
            end
        join
        @(posedge clk); #1;
        rst_n = 1'b1;
        apb_read("t6_status", A_STATUS, 32'h0000_0002);
        apb_read("t6_cmd", A_CMD, 32'h0);

        repeat (3) @(posedge clk);
        checks++;
        if (read_q.size() != 0 || probe_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d reads %0d probes pending expected 0", read_q.size(),
                     probe_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
